uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Transmit-side UART path: a 16-entry byte FIFO filled by the processor's store path, drained by an 8N1 serializer driving the `tx` pin. It is the outbound counterpart of the receive FIFO, which UART fills and the button/CPU side drains. Single clock domain; bit timing comes from an internal baud divider.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, ≥ 2.
- `CLKS_PER_BIT`, 16: `UART_CLK` cycles per serial bit; ≥ 2.
- `UART_CLK`  in  1  sole clock; all state updates on rising edge.
- `reset_n`  in  1  synchronous, active-low reset; sampled on `UART_CLK` rising edge.
- `write_req`  in  1  push `write_data` into FIFO this cycle.
- `write_data`  in  8  byte to transmit.
- `tx`  out  1  serial line; idle high; registered.
- `busy`  out  1  serializer not in IDLE.
- `empty`  out  1  FIFO count == 0.
- `full`  out  1  FIFO count == DEPTH.
- `count`  out  $clog2(DEPTH)+1  bytes currently held in FIFO; excludes byte in shifter.
- `overflow`  out  1  sticky; set when `write_req` arrives while `full`.

## Operation
- FIFO: circular buffer, `$clog2(DEPTH)`-bit read/write pointers wrapping modulo DEPTH; count tracked separately, no pointer-compare flags.
- Push: accepted iff `write_req && !full`; write pointer +1, count +1.
- Push while full: byte dropped, pointers/count unchanged, `overflow` set; cleared only by reset. Not accepted even if a pop occurs in the same cycle.
- Pop: serializer-initiated only, iff `!empty`; byte at read pointer loaded into shifter, read pointer +1, count −1.
- Push and pop in same cycle: both take effect, count unchanged. Push into empty FIFO is not popped in the same cycle.
- FSM states: IDLE, START, DATA, STOP (+ PARITY when enabled).
  - IDLE: `tx`=1. If `!empty`: pop, load shifter, bit counter=0, baud counter=0 → START.
  - START: `tx`=0 for CLKS_PER_BIT cycles → DATA.
  - DATA: `tx`=shifter[0], LSB first; shift right each bit period; after 8th bit → STOP (or PARITY).
  - STOP: `tx`=1 for CLKS_PER_BIT cycles. At end: if `!empty` pop and → START directly (no idle gap); else → IDLE.
- Baud counter counts 0..CLKS_PER_BIT−1; bit advances on terminal count.
- `busy` = state ≠ IDLE.

## Timing
- Reset values: `tx`=1, `busy`=0, `empty`=1, `full`=0, `count`=0, `overflow`=0; FSM IDLE; pointers 0.
- Flags and `count` are registered; they reflect a push/pop on the cycle after the edge that performs it.
- Write into empty FIFO with serializer idle: write sampled at edge E0; pop and START entry at E1; `tx` low from E1 through E1+CLKS_PER_BIT.
- Frame length: 10×CLKS_PER_BIT cycles (11× with parity). Back-to-back frames have zero idle cycles between stop bit and next start bit.
- Reset asserted mid-frame: on that edge FSM → IDLE, `tx`=1, FIFO flushed, `overflow` cleared; partial byte discarded.
- Writes during reset are ignored.

## Configuration
- `UART_TX_PARITY_EN` defined: PARITY state inserted between DATA and STOP; `tx` = XOR of the 8 data bits (even parity) for CLKS_PER_BIT cycles; frame = 11×CLKS_PER_BIT.
- Undefined: no PARITY state, 8N1 frame of 10×CLKS_PER_BIT; no parity logic synthesized.

## Test plan
- Reset: hold `reset_n`=0 for 3 cycles with `write_req`=1 → `tx`=1, `count`=0, `empty`=1, `overflow`=0 after release.
- Single byte, CLKS_PER_BIT=4: write 0xA5 → `tx` low 4 cycles starting the cycle after the write edge, then 1,0,1,0,0,1,0,1 each 4 cycles, high 4 cycles; `busy` 0 after 40 cycles.
- Back-to-back: write 0x00, 0xFF, 0x55 on consecutive cycles → three contiguous frames, 120 cycles total, no idle gap; `count` peaks at 2.
- Overflow: write 18 bytes on consecutive cycles with serializer stalled by first frame → first popped, 16 held, `full`=1, 18th dropped, `overflow`=1, remains 1 after FIFO drains.
- Pointer wrap: stream 40 bytes with gaps, DEPTH=16 → output byte sequence equals input sequence.
- Reset mid-frame: write 0x3C, assert `reset_n`=0 during DATA bit 3 → `tx`=1 next cycle, `busy`=0, `count`=0; no further frame emitted. With `UART_TX_PARITY_EN`, 0x07 → parity bit 1, frame 44 cycles.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Transmit-side UART: DEPTH-entry byte FIFO drained by an 8N1 serializer on tx.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_fifo #(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic                     UART_CLK,
  input  logic                     reset_n,
  input  logic                     write_req,
  input  logic [7:0]               write_data,
  output logic                     tx,
  output logic                     busy,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned BaudW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0]  CntFull  = CntW'(DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  logic [7:0]      mem_q [DEPTH];
  logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            full_q, full_d, empty_q, empty_d, ovf_q, ovf_d;
  state_e          state_q, state_d;
  logic [BaudW-1:0] baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
  logic            parity_q, parity_d;
`endif

  logic       push, load, baud_done;
  logic [7:0] head;

  assign head      = mem_q[rptr_q];
  assign baud_done = (baud_q == BaudLast);
  assign push      = write_req && !full_q;

  // Serializer next state; tx_d is the level for the state being entered.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    load    = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        load = !empty_q;
      end
      StStart: begin
        if (baud_done) begin
          baud_d  = '0;
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
          state_d = StData;
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      StData: begin
        if (baud_done) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            tx_d    = parity_q;
            state_d = StParity;
`else
            tx_d    = 1'b1;
            state_d = StStop;
`endif
          end else begin
            bit_d   = bit_q + 3'd1;
            tx_d    = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (baud_done) begin
          baud_d  = '0;
          tx_d    = 1'b1;
          state_d = StStop;
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
`endif
      StStop: begin
        if (baud_done) begin
          baud_d  = '0;
          tx_d    = 1'b1;
          state_d = StIdle;
          load    = !empty_q;
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        tx_d    = 1'b1;
      end
    endcase

    // Pop from idle or straight out of stop: no idle gap between frames.
    if (load) begin
      shift_d = head;
      bit_d   = '0;
      baud_d  = '0;
      tx_d    = 1'b0;
      state_d = StStart;
`ifdef UART_TX_PARITY_EN
      parity_d = ^head;
`endif
    end
  end

  always_comb begin
    wptr_d = push ? wptr_q + PtrW'(1) : wptr_q;
    rptr_d = load ? rptr_q + PtrW'(1) : rptr_q;
    case ({push, load})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CntFull);
    empty_d = (count_d == '0);
    ovf_d   = ovf_q | (write_req & full_q);
  end

  always_ff @(posedge UART_CLK) begin
    if (!reset_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
      state_q  <= StIdle;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      ovf_q    <= ovf_d;
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // Storage needs no reset; pointers and count define what is valid.
  always_ff @(posedge UART_CLK) begin
    if (reset_n && push) begin
      mem_q[wptr_q] <= write_data;
    end
  end

  assign tx       = tx_q;
  assign busy     = (state_q != StIdle);
  assign empty    = empty_q;
  assign full     = full_q;
  assign count    = count_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: serial-line decoder plus byte scoreboard.
module tb_uart_tx_fifo;

  localparam int CPB   = 4;
  localparam int DEPTH = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int F = NB * CPB;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       write_req = 1'b1;
  logic [7:0] write_data = 8'hEE;
  logic       tx, busy, empty, full, overflow;
  logic [4:0] count;

  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         frames = 0;
  int         peak = 0;
  logic       track_peak = 1'b0;
  logic [7:0] sb[$];
  int         starts[$];

  uart_tx_fifo #(.DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
    .UART_CLK   (clk),
    .reset_n    (reset_n),
    .write_req  (write_req),
    .write_data (write_data),
    .tx         (tx),
    .busy       (busy),
    .empty      (empty),
    .full       (full),
    .count      (count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (track_peak && int'(count) > peak) peak = int'(count);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic expbit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
    if (k == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Line decoder: samples each bit mid-period, abandons a frame cut by reset.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n && tx === 1'b0) begin
        int         st;
        logic       ok;
        logic [NB-1:0] bits;
        logic [7:0] d;
        st = cyc;
        ok = 1'b1;
        bits = '0;
        for (int k = 0; k < NB; k++) begin
          repeat ((k == 0) ? CPB / 2 : CPB) begin
            @(negedge clk);
            if (!reset_n) ok = 1'b0;
          end
          bits[k] = tx;
        end
        if (ok) begin
          frames++;
          starts.push_back(st);
          d = bits[8:1];
          chk("start_bit", 32'(bits[0]), 32'd0);
          chk("stop_bit", 32'(bits[NB-1]), 32'd1);
`ifdef UART_TX_PARITY_EN
          chk("parity_bit", 32'(bits[9]), 32'(^d));
`endif
          if (sb.size() == 0) chk("sb_underrun", 32'(d), 32'hFFFF);
          else chk("rx_byte", 32'(d), 32'(sb.pop_front()));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic push_one(input logic [7:0] b, input bit keep);
    write_req  = 1'b1;
    write_data = b;
    if (keep) sb.push_back(b);
    @(negedge clk);
    write_req = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    int i;
    for (i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (empty && !busy && sb.size() == 0) break;
    end
    if (i == max_cyc) chk("drain_timeout", 32'(i), 32'd0);
  endtask

  task automatic check_wave(input logic [7:0] b);
    push_one(b, 1'b1);
    chk("wave_s0_tx", 32'(tx), 32'd1);
    chk("wave_s0_count", 32'(count), 32'd1);
    for (int i = 1; i <= F; i++) begin
      @(negedge clk);
      chk("wave_tx", 32'(tx), 32'(expbit(b, (i - 1) / CPB)));
      if (i == 1) begin
        chk("wave_busy", 32'(busy), 32'd1);
        chk("wave_count", 32'(count), 32'd0);
      end
    end
    @(negedge clk);
    chk("wave_done_busy", 32'(busy), 32'd0);
    chk("wave_done_tx", 32'(tx), 32'd1);
  endtask

  initial begin
    // Reset with writes requested throughout.
    repeat (3) @(negedge clk);
    reset_n   = 1'b1;
    write_req = 1'b0;
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("post_rst_empty", 32'(empty), 32'd1);

    check_wave(8'hA5);
    check_wave(8'h07);

    // Back-to-back frames.
    starts.delete();
    peak       = 0;
    track_peak = 1'b1;
    push_one(8'h00, 1'b1);
    push_one(8'hFF, 1'b1);
    push_one(8'h55, 1'b1);
    wait_idle(4 * F);
    track_peak = 1'b0;
    chk("b2b_peak", 32'(peak), 32'd2);
    chk("b2b_frames", 32'(starts.size()), 32'd3);
    if (starts.size() == 3) begin
      chk("b2b_gap01", 32'(starts[1] - starts[0]), 32'(F));
      chk("b2b_gap12", 32'(starts[2] - starts[1]), 32'(F));
    end

    // Overflow: 18 consecutive writes, the last one is dropped.
    for (int i = 0; i < 18; i++) push_one(8'h10 + 8'(i), i < 17);
    chk("ovf_full", 32'(full), 32'd1);
    chk("ovf_count", 32'(count), 32'(DEPTH));
    chk("ovf_flag", 32'(overflow), 32'd1);
    wait_idle(20 * F);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    chk("ovf_drained", 32'(empty), 32'd1);

    // Pointer wrap: 40 random bytes with random gaps.
    for (int i = 0; i < 40; i++) begin
      int g;
      g = 0;
      while (full && g < 2000) begin
        @(negedge clk);
        g++;
      end
      if (g == 2000) chk("wrap_full_wait", 32'(g), 32'd0);
      push_one(8'($urandom), 1'b1);
      repeat ($urandom_range(0, 60)) @(negedge clk);
    end
    wait_idle(60 * F);
    chk("wrap_sb_empty", 32'(sb.size()), 32'd0);

    // Reset during data bit 3 of 0x3C.
    push_one(8'h3C, 1'b0);
    repeat (18) @(negedge clk);
    chk("mid_bit3", 32'(tx), 32'd1);
    chk("mid_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_tx", 32'(tx), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_ovf", 32'(overflow), 32'd0);
    reset_n = 1'b1;
    begin
      int f0;
      f0 = frames;
      repeat (3 * F) @(negedge clk);
      chk("mid_no_frame", 32'(frames), 32'(f0));
      chk("mid_idle", 32'(busy), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
